// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
// Shared types and constants for the CPU run controller.
//   state_e          : 2-bit run-controller FSM state encoding
//   DEBOUNCE_DEFAULT : default number of stable clocks needed to accept a button change
package run_ctrl_pkg;

   // The encoding is visible on the controller's state output, so the values are fixed.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      BRK  = 2'd3
   } state_e;

   localparam logic [15:0] DEBOUNCE_DEFAULT = 16'd50000;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronizes a raw push-button into the clk domain, debounces it, and produces
// a single-clock pulse whenever the debounced level goes from 0 to 1.
// Ports:
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   btn_i    : raw, asynchronous button input
//   rise_o   : one-clk pulse on a 0->1 transition of the debounced level
// Parameter:
//   DEBOUNCE_CYCLES : consecutive clocks the synchronized input must differ from
//                     the accepted level before the new level is taken
module btn_debounce
   import run_ctrl_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic rise_o
);

   logic        sync1_q;
   logic        sync2_q;
   logic        level_q;
   logic        levelDly_q;
   logic [15:0] cnt_q;

   // Two-flop synchronizer feeding a counter that only lets the accepted level
   // follow the button once it has disagreed for DEBOUNCE_CYCLES clocks in a row.
   // Any sample agreeing with the accepted level clears the count, so a bounce
   // restarts the qualification window. The >= compare keeps 0 and 1 behaving
   // as "accept on the first differing sample".
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         level_q    <= 1'b0;
         levelDly_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= btn_i;
         sync2_q    <= sync1_q;
         levelDly_q <= level_q;
         if (sync2_q != level_q) begin
            if ((cnt_q + 16'd1) >= DEBOUNCE_CYCLES) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 16'd1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   // The delayed copy makes the rising-edge pulse exactly one clock wide.
   assign rise_o = level_q & ~levelDly_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/step/breakpoint controller that turns a prescaled CPU-rate tick into a
// registered one-clock CPU clock-enable pulse, and counts the pulses issued.
// Ports:
//   clk      : system clock, all state updates on the rising edge
//   reset    : asynchronous active-low reset
//   tick     : one-clk CPU-rate strobe, synchronous to clk
//   run_sw   : free-run request level (asynchronous, synchronized here)
//   step_btn : raw single-step push-button (asynchronous, debounced here)
//   brk_addr : breakpoint compare value for the low PC byte
//   pclow    : current CPU PC low byte
//   cpu_en   : registered one-clk CPU clock-enable pulse
//   state    : current FSM state (run_ctrl_pkg::state_e encoding)
//   halted   : 1 while stopped at a breakpoint
//   cyc_cnt  : saturating count of cpu_en pulses issued
// Configuration:
//   RUN_CTRL_BRK_EN : when defined, the breakpoint compare and the BRK state are
//                     built; otherwise BRK is unreachable, halted is 0 and
//                     brk_addr/pclow are ignored.
module cpu_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int          CNT_W           = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic [7:0]       brk_addr,
   input  logic [7:0]       pclow,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] cyc_cnt
);

   logic             runSync1_q;
   logic             runSync2_q;
   logic             stepReq;
   state_e           state_q;
   logic             cpuEn_q;
   logic [CNT_W-1:0] cycCnt_q;

   // The run switch is a plain level, so a two-flop synchronizer is enough.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         runSync1_q <= 1'b0;
         runSync2_q <= 1'b0;
      end else begin
         runSync1_q <= run_sw;
         runSync2_q <= runSync1_q;
      end
   end

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_stepDebounce (
      .clk_i  (clk),
      .rst_ni (reset),
      .btn_i  (step_btn),
      .rise_o (stepReq)
   );

`ifdef RUN_CTRL_BRK_EN
   logic halted_q;
   logic brkMatch;

   // Compared in the tick clock, so a match stops the CPU before that instruction.
   assign brkMatch = (pclow == brk_addr);
`else
   logic unusedBrk;

   assign unusedBrk = ^{brk_addr, pclow};
`endif

   // Controller FSM. cpu_en is cleared every clock and set only on the clock
   // that consumes a qualifying tick, which gives the one-clock latency and
   // guarantees no back-to-back enables from a one-clock tick. A falling run
   // switch beats a simultaneous tick, and step requests arriving in RUN or
   // STEP fall through without effect because those branches ignore stepReq.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cpuEn_q  <= 1'b0;
`ifdef RUN_CTRL_BRK_EN
         halted_q <= 1'b0;
`endif
      end else begin
         cpuEn_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (runSync2_q) begin
                  state_q <= RUN;
               end else if (stepReq) begin
                  state_q <= STEP;
               end
            end
            RUN: begin
               if (!runSync2_q) begin
                  state_q <= IDLE;
`ifdef RUN_CTRL_BRK_EN
               end else if (tick && brkMatch) begin
                  state_q  <= BRK;
                  halted_q <= 1'b1;
`endif
               end else if (tick) begin
                  cpuEn_q <= 1'b1;
               end
            end
            STEP: begin
               if (tick) begin
                  cpuEn_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
`ifdef RUN_CTRL_BRK_EN
            BRK: begin
               if (!runSync2_q) begin
                  state_q  <= IDLE;
                  halted_q <= 1'b0;
               end else if (stepReq) begin
                  state_q  <= STEP;
                  halted_q <= 1'b0;
               end
            end
`else
            BRK: begin
               state_q <= IDLE;
            end
`endif
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Pulse counter sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycCnt_q <= '0;
      end else if (cpuEn_q && (cycCnt_q != '1)) begin
         cycCnt_q <= cycCnt_q + CNT_W'(1);
      end
   end

   assign cpu_en  = cpuEn_q;
   assign state   = state_q;
   assign cyc_cnt = cycCnt_q;
`ifdef RUN_CTRL_BRK_EN
   assign halted  = halted_q;
`else
   assign halted  = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl built with a 4-clock debounce and a 4-bit
// pulse counter so debounce and saturation behaviour are reachable quickly.
// The breakpoint section follows RUN_CTRL_BRK_EN.
module tb_cpu_run_ctrl;
   import run_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       runSw;
   logic       stepBtn;
   logic [7:0] brkAddr;
   logic [7:0] pcLow;
   logic       cpuEn;
   logic [1:0] state;
   logic       halted;
   logic [3:0] cycCnt;

   int compareCount = 0;
   int failCount    = 0;
   int expCnt       = 0;

   cpu_run_ctrl #(
      .DEBOUNCE_CYCLES (16'd4),
      .CNT_W           (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .run_sw   (runSw),
      .step_btn (stepBtn),
      .brk_addr (brkAddr),
      .pclow    (pcLow),
      .cpu_en   (cpuEn),
      .state    (state),
      .halted   (halted),
      .cyc_cnt  (cycCnt)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Hard stop in case something wedges the directed sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts, asserts, reports on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives tick for one clock and returns 1 time unit after the rising edge.
   task automatic applyStimulus(input logic tickVal);
      tick = tickVal;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic idleClocks(input int n);
      repeat (n) applyStimulus(1'b0);
   endtask

   // Bounded wait for a state, then a comparison on the state reached.
   task automatic waitState(input string tag, input logic [1:0] target, input int budget);
      int n = 0;
      while ((state !== target) && (n < budget)) begin
         applyStimulus(1'b0);
         n++;
      end
      checkOutput(tag, {30'd0, state}, {30'd0, target});
   endtask

   // One qualifying tick: enable must appear on the next clock only.
   task automatic tickPulse(input string tag);
      applyStimulus(1'b1);
      checkOutput({tag, "_en"}, {31'd0, cpuEn}, 32'd1);
      if (expCnt < 15) expCnt++;
      applyStimulus(1'b0);
      checkOutput({tag, "_single"}, {31'd0, cpuEn}, 32'd0);
   endtask

   initial begin
      logic seenEn;

      reset   = 1'b0;
      tick    = 1'b0;
      runSw   = 1'b0;
      stepBtn = 1'b0;
      brkAddr = 8'hFF;
      pcLow   = 8'h00;
      $display("[TB] starting cpu_run_ctrl directed sequence");

      // Held in reset with tick toggling: everything stays cleared.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i[0]);
         checkOutput("rstEn",    {31'd0, cpuEn},  32'd0);
         checkOutput("rstCnt",   {28'd0, cycCnt}, 32'd0);
         checkOutput("rstState", {30'd0, state},  32'(IDLE));
      end
      reset = 1'b1;
      idleClocks(2);
      checkOutput("postRstState", {30'd0, state}, 32'(IDLE));

      // Free run, ten ticks, no breakpoint hit.
      runSw = 1'b1;
      waitState("enterRun", 2'(RUN), 8);
      for (int i = 0; i < 10; i++) begin
         pcLow = 8'(i);
         tickPulse("freeRun");
      end
      checkOutput("freeRunCnt", {28'd0, cycCnt}, 32'd10);

      // Synchronized run switch falls in the same clock as a tick.
      runSw = 1'b0;
      idleClocks(2);
      applyStimulus(1'b1);
      checkOutput("prioEn",    {31'd0, cpuEn},  32'd0);
      checkOutput("prioState", {30'd0, state},  32'(IDLE));
      checkOutput("prioCnt",   {28'd0, cycCnt}, 32'd10);

      // Three-clock press is too short to be accepted.
      stepBtn = 1'b1;
      idleClocks(3);
      stepBtn = 1'b0;
      idleClocks(8);
      checkOutput("shortPress", {30'd0, state}, 32'(IDLE));
      applyStimulus(1'b1);
      checkOutput("shortPressEn", {31'd0, cpuEn}, 32'd0);

      // Bouncy press 1-0-1 then held: a single step.
      stepBtn = 1'b1;
      idleClocks(1);
      stepBtn = 1'b0;
      idleClocks(1);
      stepBtn = 1'b1;
      waitState("bounceStep", 2'(STEP), 14);
      idleClocks(2);
      checkOutput("stepNoTick",    {31'd0, cpuEn}, 32'd0);
      checkOutput("stepWaitState", {30'd0, state}, 32'(STEP));
      applyStimulus(1'b1);
      checkOutput("stepEn",   {31'd0, cpuEn}, 32'd1);
      checkOutput("stepDone", {30'd0, state}, 32'(IDLE));
      expCnt++;
      applyStimulus(1'b0);
      checkOutput("stepSingle", {31'd0, cpuEn}, 32'd0);
      stepBtn = 1'b0;
      idleClocks(10);
      checkOutput("stepStaysIdle", {30'd0, state},  32'(IDLE));
      checkOutput("stepCnt",       {28'd0, cycCnt}, 32'd11);

`ifdef RUN_CTRL_BRK_EN
      // Breakpoint at 8'h10: halt before it, then step past it.
      brkAddr = 8'h10;
      pcLow   = 8'h0F;
      runSw   = 1'b1;
      waitState("brkRun", 2'(RUN), 8);
      tickPulse("preBrk");
      pcLow = 8'h10;
      applyStimulus(1'b1);
      checkOutput("brkNoEn",   {31'd0, cpuEn},  32'd0);
      checkOutput("brkState",  {30'd0, state},  32'(BRK));
      checkOutput("brkHalted", {31'd0, halted}, 32'd1);
      applyStimulus(1'b1);
      checkOutput("brkHoldEn",    {31'd0, cpuEn}, 32'd0);
      checkOutput("brkHoldState", {30'd0, state}, 32'(BRK));
      stepBtn = 1'b1;
      waitState("brkStep", 2'(STEP), 14);
      stepBtn = 1'b0;
      applyStimulus(1'b1);
      checkOutput("brkStepEn",     {31'd0, cpuEn},  32'd1);
      checkOutput("brkStepState",  {30'd0, state},  32'(IDLE));
      checkOutput("brkStepHalted", {31'd0, halted}, 32'd0);
      expCnt++;
      runSw = 1'b0;
      idleClocks(10);
      checkOutput("brkExitIdle", {30'd0, state}, 32'(IDLE));
`else
      // Without breakpoint support a matching PC byte is just another tick.
      brkAddr = 8'h10;
      pcLow   = 8'h10;
      runSw   = 1'b1;
      waitState("noBrkRun", 2'(RUN), 8);
      tickPulse("noBrk");
      checkOutput("noBrkHalted", {31'd0, halted}, 32'd0);
      checkOutput("noBrkState",  {30'd0, state},  32'(RUN));
      runSw = 1'b0;
      idleClocks(4);
      checkOutput("noBrkIdle", {30'd0, state}, 32'(IDLE));
`endif
      checkOutput("cntAfterBrk", {28'd0, cycCnt}, 32'(expCnt));

      // Twenty more pulses drive the 4-bit counter into saturation.
      brkAddr = 8'hFF;
      pcLow   = 8'h00;
      runSw   = 1'b1;
      waitState("satRun", 2'(RUN), 8);
      for (int i = 0; i < 20; i++) begin
         tickPulse("sat");
      end
      checkOutput("satCnt", {28'd0, cycCnt}, 32'hF);

      // Reset while an enable is high clears it immediately; nothing follows without a tick.
      applyStimulus(1'b1);
      checkOutput("preResetEn", {31'd0, cpuEn}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("resetDropsEn", {31'd0, cpuEn},  32'd0);
      checkOutput("resetState",   {30'd0, state},  32'(IDLE));
      checkOutput("resetCnt",     {28'd0, cycCnt}, 32'd0);
      idleClocks(1);
      reset  = 1'b1;
      seenEn = 1'b0;
      repeat (6) begin
         applyStimulus(1'b0);
         seenEn = seenEn | cpuEn;
      end
      checkOutput("noPulseAfterReset", {31'd0, seenEn}, 32'd0);
      checkOutput("reRunState",        {30'd0, state},  32'(RUN));
      checkOutput("reRunCnt",          {28'd0, cycCnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000: stable-level clocks required to accept a step_btn change.
REQ-002 Parameter CNT_W, default 32: width of the executed-cycle counter.
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (low = reset).
REQ-005 tick  input  1  one-clk-wide prescaled CPU-rate strobe, synchronous to clk.
REQ-006 run_sw  input  1  level: 1 = free-run requested; asynchronous, synchronized internally.
REQ-007 step_btn  input  1  raw push-button; asynchronous, synchronized and debounced internally.
REQ-008 brk_addr  input  8  breakpoint compare value for the low PC byte.
REQ-009 pclow  input  8  current CPU PC low byte.
REQ-010 cpu_en  output  1  registered one-clk CPU clock-enable pulse.
REQ-011 state  output  2  current FSM state (encoding from package).
REQ-012 halted  output  1  1 when in BRK.
REQ-013 cyc_cnt  output  CNT_W  number of cpu_en pulses issued, saturating.

Function
REQ-014 run_sw and step_btn each pass through a 2-flop synchronizer before use.
REQ-015 The debouncer updates its accepted level only after the synchronized step_btn differs from it for DEBOUNCE_CYCLES consecutive clks; any bounce restarts the count.
REQ-016 step_req is a one-clk pulse on a 0->1 transition of the debounced level.
REQ-017 FSM states: IDLE=0, RUN=1, STEP=2, BRK=3.
REQ-018 IDLE: run_sw=1 -> RUN; else step_req -> STEP; else stay. run_sw has priority.
REQ-019 RUN: run_sw=0 -> IDLE with no enable, even if tick=1 in the same clk; else tick=1 with breakpoint match -> BRK with no enable; else tick=1 -> cpu_en=1 on the next clk.
REQ-020 Breakpoint match = (pclow == brk_addr), sampled in the tick clk; a match halts before that instruction executes.
REQ-021 STEP: the first tick issues exactly one cpu_en (next clk), then -> IDLE; breakpoints are ignored in STEP.
REQ-022 BRK: run_sw=0 -> IDLE; step_req -> STEP, which allows stepping past the breakpoint; otherwise stay. BRK is not left while run_sw stays 1.
REQ-023 step_req pulses in RUN or STEP are discarded.
REQ-024 cpu_en latency is exactly 1 clk after the qualifying tick, and it is never high for 2 consecutive clks when tick is one clk wide.
REQ-025 cyc_cnt increments by 1 on each clk with cpu_en=1 and holds at all-ones with no wrap.
REQ-026 halted = (state == BRK), registered with state.

Reset
REQ-027 On reset=0, asynchronously: state=IDLE, cpu_en=0, halted=0, cyc_cnt=0, synchronizers=0, debounce count=0, debounced level=0.
REQ-028 Reset asserted mid-STEP or mid-RUN drops cpu_en within the same reset assertion, and no pulse is issued after release until a new qualifying tick.

Configuration
REQ-029 Macro RUN_CTRL_BRK_EN: when defined, REQ-019/020/022 breakpoint logic is present.
REQ-030 When RUN_CTRL_BRK_EN is undefined, match is constant 0, BRK is unreachable, halted ties to 0, and brk_addr is unused.

Structure
REQ-031 Package run_ctrl_pkg holds the state enum typedef (2-bit) and the default debounce constant.
REQ-032 The synchronizer plus debouncer is one sub-module, btn_debounce, instantiated for step_btn only.

Verification
REQ-033 Reset: reset=0 with tick toggling -> cpu_en=0, cyc_cnt=0, state=IDLE throughout.
REQ-034 Free-run: run_sw=1, brk_addr=8'hFF, 10 ticks -> 10 cpu_en pulses, each 1 clk after its tick, cyc_cnt=10.
REQ-035 Breakpoint (macro defined): RUN with pclow reaching 8'h10=brk_addr -> no pulse for that tick, state=BRK, halted=1; a step press -> exactly 1 pulse, then IDLE.
REQ-036 Debounce (DEBOUNCE_CYCLES=4): step_btn bounces 1-0-1 within 3 clks, then holds 1 -> exactly one STEP pulse; a 3-clk press -> none.
REQ-037 Priority: in RUN, run_sw falls in the same clk as tick -> no cpu_en, state=IDLE.
REQ-038 Saturation (CNT_W=4): 20 pulses -> cyc_cnt holds at 4'hF.
